// File: rtl/ccip_mmio_csr_responder.sv
// CCI-P MMIO responder: 64-bit CSR file with buffered, in-order read responses.
// Writes update the CSR file directly; reads go stage 1 -> response FIFO -> output register.
module ccip_mmio_csr_responder #(
  parameter int          NUM_CSR             = 16,
  parameter int          RSP_FIFO_DEPTH_LOG2 = 2,
  parameter logic [63:0] CSR0_VALUE          = 64'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mmio_wr_valid,
  input  logic                           mmio_rd_valid,
  input  logic [27:0]                    cfg_hdr,
  input  logic [63:0]                    cfg_wrdata,
  input  logic                           rsp_stall,
  output logic                           mmio_rsp_valid,
  output logic [8:0]                     mmio_rsp_tid,
  output logic [63:0]                    mmio_rsp_data,
  output logic [NUM_CSR-1:0]             csr_wr_strobe,
  output logic                           req_drop,
  output logic [RSP_FIFO_DEPTH_LOG2:0]   rsp_pending
);

  localparam int          IDX_W     = $clog2(NUM_CSR);
  localparam int          DEPTH     = 1 << RSP_FIFO_DEPTH_LOG2;
  localparam int          CNT_W     = RSP_FIFO_DEPTH_LOG2 + 1;
  localparam int          PTR_W     = RSP_FIFO_DEPTH_LOG2;
  localparam logic [15:0] NUM_CSR_W = 16'(NUM_CSR);

  logic [15:0]      index;
  logic [1:0]       len;
  logic [8:0]       tid;
  logic [14:0]      sel;
  logic [IDX_W-1:0] csr_idx;
  logic             unused_rsvd;

  assign index       = cfg_hdr[27:12];
  assign len         = cfg_hdr[11:10];
  assign tid         = cfg_hdr[8:0];
  assign sel         = index[15:1];
  assign csr_idx     = sel[IDX_W-1:0];
  assign unused_rsvd = cfg_hdr[9];

  logic in_range, len_4b, len_8b, access_ok, wr_apply;
  logic pending_full, rd_accept, rd_drop, pop;

  assign in_range     = {1'b0, sel} < NUM_CSR_W;
  assign len_4b       = (len == 2'b00);
  assign len_8b       = (len == 2'b01);
  assign access_ok    = in_range && (len_4b || (len_8b && !index[0]));
  assign wr_apply     = mmio_wr_valid && access_ok && (sel != 15'd0);
  assign pending_full = (rsp_pending == CNT_W'(DEPTH));
  // A read colliding with a write loses; the write still goes through.
  assign rd_accept    = mmio_rd_valid && !mmio_wr_valid && !pending_full;
  assign rd_drop      = mmio_rd_valid && (mmio_wr_valid || pending_full);

  logic [63:0] csr [NUM_CSR];
  logic [63:0] csr_word;
  logic [63:0] rd_data;

  assign csr_word = (csr_idx == '0) ? CSR0_VALUE : csr[csr_idx];

  always_comb begin
    rd_data = '0;
    if (access_ok) begin
      if (len_8b)
        rd_data = csr_word;
      else
        rd_data = {32'h0, index[0] ? csr_word[63:32] : csr_word[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CSR; i++)
        csr[i] <= '0;
    end else if (wr_apply) begin
      if (len_8b)
        csr[csr_idx] <= cfg_wrdata;
      else if (index[0])
        csr[csr_idx][63:32] <= cfg_wrdata[31:0];
      else
        csr[csr_idx][31:0] <= cfg_wrdata[31:0];
    end
  end

  logic             s1_valid;
  logic [8:0]       s1_tid;
  logic [63:0]      s1_data;
  logic [8:0]       fifo_tid  [DEPTH];
  logic [63:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  assign pop = (fifo_count != '0) && !rsp_stall;

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      fifo_tid[wr_ptr]  <= s1_tid;
      fifo_data[wr_ptr] <= s1_data;
    end
  end

  // rsp_pending counts stage 1 plus FIFO, so bounding it keeps the FIFO from overflowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_tid         <= '0;
      s1_data        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= '0;
      mmio_rsp_data  <= '0;
      rsp_pending    <= '0;
      req_drop       <= 1'b0;
      csr_wr_strobe  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_tid  <= tid;
        s1_data <= rd_data;
      end
      if (s1_valid)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(s1_valid) - CNT_W'(pop);

      mmio_rsp_valid <= pop;
      if (pop) begin
        mmio_rsp_tid  <= fifo_tid[rd_ptr];
        mmio_rsp_data <= fifo_data[rd_ptr];
      end

      case ({rd_accept, pop})
        2'b10:   rsp_pending <= rsp_pending + 1'b1;
        2'b01:   rsp_pending <= rsp_pending - 1'b1;
        default: rsp_pending <= rsp_pending;
      endcase

      req_drop      <= rd_drop;
      csr_wr_strobe <= wr_apply ? (NUM_CSR'(1) << csr_idx) : '0;
    end
  end

endmodule
